// File: rtl/psram_txn_sched.sv
// Round-robin transaction scheduler for the shared PSRAM engine: arbitration,
// OPI burst rule check, single-transaction issue and timeout supervision.
module psram_txn_sched #(
    parameter int REQ_NUM        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          en_i,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    input  logic [REQ_NUM-1:0]            req_wr_i,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [REQ_NUM*LEN_WIDTH-1:0]  req_len_i,
    output logic [REQ_NUM-1:0]            rsp_valid_o,
    output logic                          rsp_err_o,
    output logic [$clog2(REQ_NUM)-1:0]    gnt_id_o,
    output logic                          busy_o,
    output logic                          eng_start_o,
    output logic [1:0]                    eng_cmd_o,
    output logic [ADDR_WIDTH-1:0]         eng_addr_o,
    output logic [LEN_WIDTH-1:0]          eng_len_o,
    input  logic                          eng_done_i,
    output logic                          eng_abort_o
);
    localparam int GW = $clog2(REQ_NUM);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]         gnt_q, gnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [GW-1:0]         win;
    logic                  found;
    int                    idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [LEN_WIDTH-1:0]  win_len;
    logic                  win_wr;
    logic                  illegal;

    // Descending scan so the lowest offset from rr_ptr is the last to be written.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            if (en_i && req_valid_i[idx]) begin
                win   = GW'(idx);
                found = 1'b1;
            end
        end
    end

    assign win_addr = req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len  = req_len_i[win*LEN_WIDTH +: LEN_WIDTH];
    assign win_wr   = req_wr_i[win];
    assign illegal  = win_addr[0] | (win_wr & (win_len == '0));

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_err_o   = 1'b0;
        eng_start_o = 1'b0;
        eng_cmd_o   = 2'b00;
        eng_abort_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_o = REQ_NUM'(1) << win;
                    gnt_d       = win;
                    wr_d        = win_wr;
                    addr_d      = win_addr;
                    len_d       = win_len;
                    state_d     = illegal ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                eng_start_o = 1'b1;
                eng_cmd_o   = wr_q ? 2'b01 : 2'b10;
                cnt_d       = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                eng_cmd_o = wr_q ? 2'b01 : 2'b10;
                cnt_d     = cnt_q + 1'b1;
                if (eng_done_i) begin
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    eng_abort_o = 1'b1;
                    state_d     = ERR;
                end
            end
            RESP, ERR: begin
                rsp_valid_o = REQ_NUM'(1) << gnt_q;
                rsp_err_o   = (state_q == ERR);
                rr_ptr_d    = (gnt_q == GW'(REQ_NUM - 1)) ? '0 : gnt_q + 1'b1;
                cnt_d       = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt_id_o   = gnt_q;
    assign busy_o     = (state_q != IDLE);
    assign eng_addr_o = addr_q;
    assign eng_len_o  = len_q;
endmodule

// File: tb/tb_psram_txn_sched.sv
// Directed bench for psram_txn_sched: vector table of single transactions plus
// hand-written round-robin, timeout, enable and reset sequences.
module tb_psram_txn_sched;
    localparam int RN = 2;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [RN-1:0]   req_valid, req_ready, req_wr, rsp_valid;
    logic [RN*AW-1:0] req_addr;
    logic [RN*LW-1:0] req_len;
    logic            rsp_err, busy, eng_start, eng_done, eng_abort;
    logic [0:0]      gnt_id;
    logic [1:0]      eng_cmd;
    logic [AW-1:0]   eng_addr;
    logic [LW-1:0]   eng_len;

    int n_cmp = 0;
    int n_bad = 0;

    psram_txn_sched #(.REQ_NUM(RN), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
        .req_addr_i(req_addr), .req_len_i(req_len),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .gnt_id_o(gnt_id), .busy_o(busy),
        .eng_start_o(eng_start), .eng_cmd_o(eng_cmd), .eng_addr_o(eng_addr), .eng_len_o(eng_len),
        .eng_done_i(eng_done), .eng_abort_o(eng_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        int          delay;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic wr, input logic [31:0] addr, input logic [7:0] len);
        req_valid[id]          = 1'b1;
        req_wr[id]             = wr;
        req_addr[id*AW +: AW]  = addr;
        req_len[id*LW +: LW]   = len;
    endtask

    task automatic txn(input vec_t v);
        logic [1:0] cmd;
        cmd = v.wr ? 2'b01 : 2'b10;
        req_valid = '0;
        set_req(v.id, v.wr, v.addr, v.len);
        #1 chk("ready", 64'(req_ready), 64'(1) << v.id);
        tick();
        req_valid = '0;
        chk("gnt_id", 64'(gnt_id), 64'(v.id));
        chk("busy", 64'(busy), 64'd1);
        if (v.err) begin
            chk("err_rsp_valid", 64'(rsp_valid), 64'(1) << v.id);
            chk("err_rsp_err", 64'(rsp_err), 64'd1);
            chk("err_no_start", 64'(eng_start), 64'd0);
            tick();
            chk("err_idle", 64'(busy), 64'd0);
            chk("err_rsp_clear", 64'(rsp_valid), 64'd0);
        end else begin
            chk("start", 64'(eng_start), 64'd1);
            chk("start_cmd", 64'(eng_cmd), 64'(cmd));
            chk("start_addr", 64'(eng_addr), 64'(v.addr));
            chk("start_len", 64'(eng_len), 64'(v.len));
            for (int k = 1; k < v.delay; k++) begin
                tick();
                chk("wait_start_low", 64'(eng_start), 64'd0);
                chk("wait_cmd", 64'(eng_cmd), 64'(cmd));
                chk("wait_no_rsp", 64'(rsp_valid), 64'd0);
            end
            tick();
            eng_done = 1'b1;
            #1 chk("done_no_abort", 64'(eng_abort), 64'd0);
            tick();
            eng_done = 1'b0;
            chk("rsp_valid", 64'(rsp_valid), 64'(1) << v.id);
            chk("rsp_err", 64'(rsp_err), 64'd0);
            chk("rsp_cmd_idle", 64'(eng_cmd), 64'd0);
            tick();
            chk("back_idle", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req_valid = '0; req_wr = '0;
        req_addr = '0; req_len = '0; eng_done = 1'b0;
        vecs[0] = '{0, 1'b0, 32'h100, 8'd7, 5, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h201, 8'd3, 1, 1'b1};
        vecs[2] = '{1, 1'b1, 32'h200, 8'd0, 1, 1'b1};
        vecs[3] = '{1, 1'b0, 32'h200, 8'd0, 1, 1'b0};
        vecs[4] = '{0, 1'b1, 32'h300, 8'd1, 2, 1'b0};
        vecs[5] = '{1, 1'b0, 32'h401, 8'd4, 1, 1'b1};

        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd", 64'(eng_cmd), 64'd0);
        chk("rst_rsp", 64'(rsp_valid), 64'd0);
        chk("rst_gnt", 64'(gnt_id), 64'd0);
        chk("rst_addr", 64'(eng_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        // Enable low blocks grants.
        set_req(0, 1'b0, 32'h10, 8'd1);
        #1 chk("en_low_ready", 64'(req_ready), 64'd0);
        tick();
        chk("en_low_busy", 64'(busy), 64'd0);
        req_valid = '0;
        en = 1'b1;

        for (int i = 0; i < 6; i++) txn(vecs[i]);

        // Round robin: both valid continuously; last grant was req1 so req0 is first.
        set_req(0, 1'b1, 32'h1000, 8'd1);
        set_req(1, 1'b1, 32'h2000, 8'd1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("rr_ready", 64'(req_ready), 64'(1) << (i % 2));
            tick();
            chk("rr_gnt", 64'(gnt_id), 64'(i % 2));
            chk("rr_ready_issue", 64'(req_ready), 64'd0);
            tick();
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
            chk("rr_rsp", 64'(rsp_valid), 64'(1) << (i % 2));
            tick();
        end
        req_valid = '0;

        // Timeout: read from req0, done never comes.
        set_req(0, 1'b0, 32'h40, 8'd3);
        tick();
        req_valid = '0;
        chk("to_start", 64'(eng_start), 64'd1);
        tick();
        for (int w = 1; w < TO; w++) begin
            chk("to_no_abort", 64'(eng_abort), 64'd0);
            tick();
        end
        chk("to_abort", 64'(eng_abort), 64'd1);
        chk("to_cmd_held", 64'(eng_cmd), 64'd2);
        tick();
        chk("to_abort_pulse", 64'(eng_abort), 64'd0);
        chk("to_rsp", 64'(rsp_valid), 64'd1);
        chk("to_rsp_err", 64'(rsp_err), 64'd1);
        tick();
        txn('{1, 1'b1, 32'h80, 8'd5, 1, 1'b0});

        // Done coincident with last timeout cycle: done wins.
        set_req(0, 1'b0, 32'h60, 8'd2);
        tick();
        req_valid = '0;
        tick();
        for (int w = 1; w < TO; w++) tick();
        eng_done = 1'b1;
        #1 chk("coinc_no_abort", 64'(eng_abort), 64'd0);
        tick();
        eng_done = 1'b0;
        chk("coinc_rsp", 64'(rsp_valid), 64'd1);
        chk("coinc_err", 64'(rsp_err), 64'd0);
        tick();

        // Enable dropped during WAIT: completes, then no grant until re-enabled.
        set_req(1, 1'b0, 32'h500, 8'd2);
        tick();
        req_valid = '0;
        tick();
        en = 1'b0;
        set_req(0, 1'b0, 32'h600, 8'd2);
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("en_drop_rsp", 64'(rsp_valid), 64'd2);
        chk("en_drop_err", 64'(rsp_err), 64'd0);
        tick();
        chk("en_drop_ready", 64'(req_ready), 64'd0);
        tick();
        chk("en_drop_idle", 64'(busy), 64'd0);
        en = 1'b1;
        #1 chk("en_back_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = '0;
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();

        // Reset in WAIT of a req1 transaction while rr_ptr points at req1.
        set_req(1, 1'b1, 32'h700, 8'd3);
        tick();
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_cmd", 64'(eng_cmd), 64'd0);
        chk("mrst_abort", 64'(eng_abort), 64'd0);
        chk("mrst_addr", 64'(eng_addr), 64'd0);
        chk("mrst_gnt", 64'(gnt_id), 64'd0);
        tick();
        chk("mrst_no_rsp", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        set_req(0, 1'b1, 32'h800, 8'd1);
        set_req(1, 1'b1, 32'h900, 8'd1);
        #1 chk("mrst_rr_ptr0", 64'(req_ready), 64'd1);
        tick();
        req_valid = '0;
        chk("mrst_gnt0", 64'(gnt_id), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
